// File: rtl/diclock_ctrl.sv
// diclock_ctrl: mode controller and enable sequencer for the digital clock.
// Divides clk into a 1 Hz count tick and a 2 Hz blink toggle. Runs the
// RUN / SET_HOUR / SET_MIN state machine from debounced buttons. Issues
// one-cycle enables to the sec/min/hour BCD counters and blanks the field
// currently being set.
// Ports:
//   clk, cr        - clock, synchronous active-high clear
//   btn_mode       - one-cycle pulse, advance mode
//   btn_inc        - one-cycle pulse, increment selected field
//   secH/secL      - seconds BCD digits read back from the counter
//   minH/minL      - minutes BCD digits read back from the counter
//   sec_en/min_en/hour_en - registered one-cycle counter enables
//   sec_clr        - registered one-cycle seconds clear on SET_MIN -> RUN
//   mode           - registered state: 0 RUN, 1 SET_HOUR, 2 SET_MIN
//   blank_h/blank_m - registered display blanking for the field being set
module diclock_ctrl #(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] secH,
  input  logic [3:0] secL,
  input  logic [3:0] minH,
  input  logic [3:0] minL,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blank_h,
  output logic       blank_m
);

  localparam int unsigned HALF_CNT = CLK_HZ / 2;
  localparam int unsigned DIV_W    = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_CNT - 1);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] SET_HOUR = 2'd1;
  localparam logic [1:0] SET_MIN  = 2'd2;

  logic [DIV_W-1:0] divCnt;
  logic             half;
  logic             blink;
  logic             divWrap;
  logic             tick1;

  logic [1:0] modeNext;
  logic       secEnNext;
  logic       minEnNext;
  logic       hourEnNext;
  logic       secClrNext;
  logic       blankHNext;
  logic       blankMNext;
  logic       secs59;
  logic       mins59;

  // Half-second prescaler; tick1 fires on the wrap that closes each full
  // second, so the first tick comes a whole second after clear.
  assign divWrap = (divCnt == DIV_LAST);
  assign tick1   = divWrap & half;

  always_ff @(posedge clk) begin
    if (cr) begin
      divCnt <= '0;
      half   <= 1'b0;
      blink  <= 1'b0;
    end else if (divWrap) begin
      divCnt <= '0;
      half   <= ~half;
      blink  <= ~blink;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  // Exact-match compare: non-BCD readback never produces a carry.
  assign secs59 = (secH == 4'd5) && (secL == 4'd9);
  assign mins59 = (minH == 4'd5) && (minL == 4'd9);

  // Next-state and next-output decode; enables come from the current state
  // so a tick coinciding with a mode change out of RUN is still honoured.
  always_comb begin
    modeNext   = mode;
    secEnNext  = 1'b0;
    minEnNext  = 1'b0;
    hourEnNext = 1'b0;
    secClrNext = 1'b0;
    case (mode)
      RUN: begin
        if (btn_mode) modeNext = SET_HOUR;
        if (tick1) begin
          secEnNext  = 1'b1;
          minEnNext  = secs59;
          hourEnNext = secs59 & mins59;
        end
      end
      SET_HOUR: begin
        if (btn_mode)     modeNext   = SET_MIN;
        else if (btn_inc) hourEnNext = 1'b1;
      end
      SET_MIN: begin
        if (btn_mode) begin
          modeNext   = RUN;
          secClrNext = 1'b1;
        end else if (btn_inc) begin
          minEnNext = 1'b1;
        end
      end
      default: modeNext = RUN;
    endcase
    // Gate on the next mode so blanking drops together with leaving the state.
    blankHNext = (modeNext == SET_HOUR) & blink;
    blankMNext = (modeNext == SET_MIN) & blink;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (cr) begin
      mode    <= RUN;
      sec_en  <= 1'b0;
      min_en  <= 1'b0;
      hour_en <= 1'b0;
      sec_clr <= 1'b0;
      blank_h <= 1'b0;
      blank_m <= 1'b0;
    end else begin
      mode    <= modeNext;
      sec_en  <= secEnNext;
      min_en  <= minEnNext;
      hour_en <= hourEnNext;
      sec_clr <= secClrNext;
      blank_h <= blankHNext;
      blank_m <= blankMNext;
    end
  end

endmodule

// File: tb/tb_diclock_ctrl.sv
// Directed testbench for diclock_ctrl with CLK_HZ = 4 (tick every 4 cycles).
module tb_diclock_ctrl;

  logic       clk;
  logic       cr;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] secH;
  logic [3:0] secL;
  logic [3:0] minH;
  logic [3:0] minL;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic       sec_clr;
  logic [1:0] mode;
  logic       blank_h;
  logic       blank_m;

  int unsigned checks;
  int unsigned failures;
  int          n;
  int          pulses;
  logic        incNow;

  diclock_ctrl #(.CLK_HZ(4)) dut (
    .clk     (clk),
    .cr      (cr),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .secH    (secH),
    .secL    (secL),
    .minH    (minH),
    .minL    (minL),
    .sec_en  (sec_en),
    .min_en  (min_en),
    .hour_en (hour_en),
    .sec_clr (sec_clr),
    .mode    (mode),
    .blank_h (blank_h),
    .blank_m (blank_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Expected blink register value m cycles after clear release.
  function automatic logic blinkAt(input int m);
    return logic'((m >> 1) & 1);
  endfunction

  task automatic setDigits(input logic [3:0] sh, input logic [3:0] sl,
                           input logic [3:0] mh, input logic [3:0] ml);
    secH = sh; secL = sl; minH = mh; minL = ml;
  endtask

  initial begin
    checks = 0; failures = 0; n = 0;
    cr = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    setDigits(4'd0, 4'd0, 4'd0, 4'd0);

    // Reset held for two cycles
    step(); step();
    checkVal("rst_mode", 32'(mode), 0);
    checkVal("rst_sec_en", 32'(sec_en), 0);
    checkVal("rst_min_en", 32'(min_en), 0);
    checkVal("rst_hour_en", 32'(hour_en), 0);
    checkVal("rst_sec_clr", 32'(sec_clr), 0);
    checkVal("rst_blank_h", 32'(blank_h), 0);
    checkVal("rst_blank_m", 32'(blank_m), 0);

    // Release: sec_en pulses 4 cycles later, then every 4 cycles
    cr = 1'b0; n = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checkVal("prescale_sec_en", 32'(sec_en), (n % 4 == 0) ? 1 : 0);
      checkVal("prescale_min_en", 32'(min_en), 0);
    end

    // Carry chain at 59:59
    setDigits(4'd5, 4'd9, 4'd5, 4'd9);
    repeat (4) step();
    checkVal("c5959_sec_en", 32'(sec_en), 1);
    checkVal("c5959_min_en", 32'(min_en), 1);
    checkVal("c5959_hour_en", 32'(hour_en), 1);

    // Seconds 58: no carry
    setDigits(4'd5, 4'd8, 4'd5, 4'd9);
    repeat (4) step();
    checkVal("c58_sec_en", 32'(sec_en), 1);
    checkVal("c58_min_en", 32'(min_en), 0);
    checkVal("c58_hour_en", 32'(hour_en), 0);

    // 58:59 carries into minutes only
    setDigits(4'd5, 4'd9, 4'd5, 4'd8);
    repeat (4) step();
    checkVal("c5859_sec_en", 32'(sec_en), 1);
    checkVal("c5859_min_en", 32'(min_en), 1);
    checkVal("c5859_hour_en", 32'(hour_en), 0);

    // Non-BCD seconds units: no carry
    setDigits(4'd5, 4'hF, 4'd5, 4'd9);
    repeat (4) step();
    checkVal("nbcd_sec_en", 32'(sec_en), 1);
    checkVal("nbcd_min_en", 32'(min_en), 0);
    checkVal("nbcd_hour_en", 32'(hour_en), 0);
    setDigits(4'd0, 4'd0, 4'd0, 4'd0);

    // Mode cycling RUN -> SET_HOUR -> SET_MIN -> RUN (n = 24)
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checkVal("cyc1_mode", 32'(mode), 1);
    checkVal("cyc1_sec_clr", 32'(sec_clr), 0);
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checkVal("cyc2_mode", 32'(mode), 2);
    checkVal("cyc2_sec_clr", 32'(sec_clr), 0);
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checkVal("cyc3_mode", 32'(mode), 0);
    checkVal("cyc3_sec_clr", 32'(sec_clr), 1);
    step();
    checkVal("cyc4_sec_clr", 32'(sec_clr), 0);
    checkVal("cyc4_sec_en", 32'(sec_en), 1);

    // SET_HOUR: 3 inc pulses over 10 ticks, clock paused, blank_h blinks
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checkVal("sh_mode", 32'(mode), 1);
    checkVal("sh_blank_h0", 32'(blank_h), 32'(blinkAt(n - 1)));
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      incNow = (i == 3) || (i == 10) || (i == 25);
      btn_inc = incNow;
      step();
      btn_inc = 1'b0;
      checkVal("sh_hour_en", 32'(hour_en), 32'(incNow));
      checkVal("sh_sec_en", 32'(sec_en), 0);
      checkVal("sh_min_en", 32'(min_en), 0);
      checkVal("sh_blank_h", 32'(blank_h), 32'(blinkAt(n - 1)));
      checkVal("sh_blank_m", 32'(blank_m), 0);
      if (hour_en) pulses++;
    end
    checkVal("sh_hour_pulses", 32'(pulses), 3);
    checkVal("sh_mode_hold", 32'(mode), 1);

    // Collision: mode wins, inc dropped (n = 69)
    btn_mode = 1'b1; btn_inc = 1'b1; step(); btn_mode = 1'b0; btn_inc = 1'b0;
    checkVal("col_mode", 32'(mode), 2);
    checkVal("col_hour_en", 32'(hour_en), 0);
    checkVal("col_min_en", 32'(min_en), 0);
    checkVal("col_blank_h", 32'(blank_h), 0);
    checkVal("col_blank_m", 32'(blank_m), 32'(blinkAt(n - 1)));

    // SET_MIN increment; blink is high here
    btn_inc = 1'b1; step(); btn_inc = 1'b0;
    checkVal("sm_min_en", 32'(min_en), 1);
    checkVal("sm_hour_en", 32'(hour_en), 0);
    checkVal("sm_sec_en", 32'(sec_en), 0);
    checkVal("sm_blank_m", 32'(blank_m), 1);

    // Reset in SET_MIN with blank_m high
    cr = 1'b1; step();
    checkVal("rst2_mode", 32'(mode), 0);
    checkVal("rst2_blank_m", 32'(blank_m), 0);
    checkVal("rst2_sec_clr", 32'(sec_clr), 0);
    checkVal("rst2_min_en", 32'(min_en), 0);

    // Tick coinciding with leaving RUN is honoured
    cr = 1'b0; n = 0;
    repeat (3) step();
    btn_mode = 1'b1; step(); btn_mode = 1'b0;
    checkVal("tickmode_mode", 32'(mode), 1);
    checkVal("tickmode_sec_en", 32'(sec_en), 1);
    step();
    checkVal("tickmode_sec_en_next", 32'(sec_en), 0);
    checkVal("tickmode_mode_next", 32'(mode), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
